// File: rtl/mem_stage.sv
// MIPS memory-access stage: word-addressed data memory with wait states,
// MEM/WB pipeline register, branch decision and forwarding buses.
module mem_stage #(
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_branch_pc,
  input  logic [31:0] i_result,
  input  logic        i_zero,
  input  logic [31:0] i_write_data,
  input  logic [4:0]  i_write_reg,
  input  logic [1:0]  i_WB_control,
  input  logic [2:0]  i_MEM_control,
  output logic [31:0] o_branch_pc,
  output logic        o_pc_src,
  output logic        o_stall,
  output logic [31:0] MEM_D,
  output logic [31:0] o_read_data,
  output logic [31:0] o_result,
  output logic [4:0]  o_write_reg,
  output logic [1:0]  o_WB_control,
  output logic [31:0] WB_D
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [3:0] LAT_M1 = (MEM_LAT == 0) ? 4'd0 : 4'(MEM_LAT - 1);
  localparam bit         HAS_WAIT = (MEM_LAT != 0);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic              w_access;
  logic              w_stall;
  logic              w_complete;
  logic              w_mem_we;
  logic              w_rd_wr_both;
  logic [ADDR_W-1:0] w_addr;

  logic [31:0]       r_mem [2**ADDR_W];
  logic [31:0]       r_read_data;
  logic [31:0]       r_result;
  logic [4:0]        r_write_reg;
  logic [1:0]        r_wb_control;

  assign w_access     = i_MEM_control[1] | i_MEM_control[0];
  assign w_rd_wr_both = i_MEM_control[1] & i_MEM_control[0];
  assign w_addr       = i_result[ADDR_W+1:2];

  // Stall for MEM_LAT cycles on an access; complete on the first non-stall cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    w_complete  = 1'b0;
    if (!i_rst) begin
      case (r_state)
        S_IDLE: begin
          if (w_access && HAS_WAIT) begin
            w_stall     = 1'b1;
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = LAT_M1;
          end else begin
            w_complete = 1'b1;
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            w_stall   = 1'b1;
            w_cnt_nxt = r_cnt - 4'd1;
          end else begin
            w_complete  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // MEM/WB register: bubble while stalled, capture on completion.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_read_data  <= 32'd0;
      r_result     <= 32'd0;
      r_write_reg  <= 5'd0;
      r_wb_control <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_stall) begin
        r_wb_control <= 2'b00;
      end else if (w_complete) begin
        r_result     <= i_result;
        r_write_reg  <= i_write_reg;
        r_wb_control <= i_WB_control;
        if (w_rd_wr_both) begin
          r_read_data <= 32'd0;
        end else if (i_MEM_control[1]) begin
          r_read_data <= r_mem[w_addr];
        end
      end
    end
  end

  // Memory contents survive reset; a store commits only on its completion edge.
  assign w_mem_we = w_complete & i_MEM_control[0];

  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      r_mem[w_addr] <= i_write_data;
    end
  end

  assign o_branch_pc  = i_branch_pc;
  assign o_pc_src     = i_MEM_control[2] & i_zero;
  assign o_stall      = w_stall;
  assign MEM_D        = i_result;
  assign o_read_data  = r_read_data;
  assign o_result     = r_result;
  assign o_write_reg  = r_write_reg;
  assign o_WB_control = r_wb_control;
  assign WB_D         = r_wb_control[0] ? r_read_data : r_result;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: one instance with MEM_LAT=2, one with MEM_LAT=0.
module tb_mem_stage;

  localparam int LAT_A = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bpc, res, wd;
  logic        zero;
  logic [4:0]  wr;
  logic [1:0]  wbc;
  logic [2:0]  memc;

  logic [31:0] a_bpc, a_memd, a_rd, a_res, a_wbd;
  logic        a_pcsrc, a_stall;
  logic [4:0]  a_wr;
  logic [1:0]  a_wbc;
  logic [31:0] z_bpc, z_memd, z_rd, z_res, z_wbd;
  logic        z_pcsrc, z_stall;
  logic [4:0]  z_wr;
  logic [1:0]  z_wbc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_W(8), .MEM_LAT(LAT_A)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_branch_pc(bpc), .i_result(res), .i_zero(zero),
    .i_write_data(wd), .i_write_reg(wr), .i_WB_control(wbc), .i_MEM_control(memc),
    .o_branch_pc(a_bpc), .o_pc_src(a_pcsrc), .o_stall(a_stall), .MEM_D(a_memd),
    .o_read_data(a_rd), .o_result(a_res), .o_write_reg(a_wr), .o_WB_control(a_wbc),
    .WB_D(a_wbd)
  );

  mem_stage #(.ADDR_W(8), .MEM_LAT(0)) dut_z (
    .i_clk(clk), .i_rst(rst), .i_branch_pc(bpc), .i_result(res), .i_zero(zero),
    .i_write_data(wd), .i_write_reg(wr), .i_WB_control(wbc), .i_MEM_control(memc),
    .o_branch_pc(z_bpc), .o_pc_src(z_pcsrc), .o_stall(z_stall), .MEM_D(z_memd),
    .o_read_data(z_rd), .o_result(z_res), .o_write_reg(z_wr), .o_WB_control(z_wbc),
    .WB_D(z_wbd)
  );

  // Runs the presented instruction to completion; reports stall cycles and
  // how many post-stall-edge samples showed a non-bubble WB control.
  task automatic exec(input bit use_z, output int stalls, output int bubble_bad);
    bit done;
    stalls = 0;
    bubble_bad = 0;
    done = 0;
    #1;
    for (int i = 0; i < 40 && !done; i++) begin
      if ((use_z ? z_stall : a_stall) === 1'b1) begin
        stalls++;
        @(posedge clk); #1;
        if ((use_z ? z_wbc : a_wbc) !== 2'b00) bubble_bad++;
      end else begin
        @(posedge clk); #1;
        done = 1;
      end
    end
    if (!done) stalls = 99;
  endtask

  task automatic pulse_reset();
    rst = 1'b1; memc = 3'b000;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bpc = $urandom; res = $urandom; wd = $urandom; zero = 1'b0;
    wr = 5'($urandom); wbc = 2'b11; memc = 3'b010;
    #1;
    checks++; if (a_stall !== 1'b0) begin failures++; $display("FAIL rst_stall_a got=%b exp=0", a_stall); end
    @(posedge clk); #1;
    checks++; if (a_stall !== 1'b0) begin failures++; $display("FAIL rst_stall_a2 got=%b exp=0", a_stall); end
    checks++; if (z_stall !== 1'b0) begin failures++; $display("FAIL rst_stall_z got=%b exp=0", z_stall); end
    checks++; if (a_rd !== 32'd0) begin failures++; $display("FAIL rst_rd_a got=%h exp=0", a_rd); end
    checks++; if (a_res !== 32'd0) begin failures++; $display("FAIL rst_res_a got=%h exp=0", a_res); end
    checks++; if (a_wr !== 5'd0) begin failures++; $display("FAIL rst_wr_a got=%h exp=0", a_wr); end
    checks++; if (a_wbc !== 2'd0) begin failures++; $display("FAIL rst_wbc_a got=%h exp=0", a_wbc); end
    checks++; if (a_wbd !== 32'd0) begin failures++; $display("FAIL rst_wbd_a got=%h exp=0", a_wbd); end
    checks++; if (z_rd !== 32'd0) begin failures++; $display("FAIL rst_rd_z got=%h exp=0", z_rd); end
    checks++; if (z_res !== 32'd0) begin failures++; $display("FAIL rst_res_z got=%h exp=0", z_res); end
    checks++; if (z_wbc !== 2'd0) begin failures++; $display("FAIL rst_wbc_z got=%h exp=0", z_wbc); end
    checks++; if (z_wbd !== 32'd0) begin failures++; $display("FAIL rst_wbd_z got=%h exp=0", z_wbd); end
    rst = 1'b0; memc = 3'b000;
  endtask

  task automatic test_rtype();
    int st, bb;
    memc = 3'b000; res = 32'h1234; wr = 5'd5; wbc = 2'b10; zero = 1'b0;
    #1;
    checks++; if (a_memd !== 32'h1234) begin failures++; $display("FAIL rtype_memd got=%h exp=1234", a_memd); end
    exec(1'b0, st, bb);
    checks++; if (st !== 0) begin failures++; $display("FAIL rtype_stalls got=%0d exp=0", st); end
    checks++; if (a_res !== 32'h1234) begin failures++; $display("FAIL rtype_res got=%h exp=1234", a_res); end
    checks++; if (a_wr !== 5'd5) begin failures++; $display("FAIL rtype_wr got=%0d exp=5", a_wr); end
    checks++; if (a_wbc !== 2'b10) begin failures++; $display("FAIL rtype_wbc got=%b exp=10", a_wbc); end
    checks++; if (a_wbd !== 32'h1234) begin failures++; $display("FAIL rtype_wbd got=%h exp=1234", a_wbd); end
  endtask

  task automatic test_branch();
    memc = 3'b100; zero = 1'b1; bpc = 32'h40;
    #1;
    checks++; if (a_pcsrc !== 1'b1) begin failures++; $display("FAIL br_taken got=%b exp=1", a_pcsrc); end
    checks++; if (a_bpc !== 32'h40) begin failures++; $display("FAIL br_pc got=%h exp=40", a_bpc); end
    checks++; if (a_stall !== 1'b0) begin failures++; $display("FAIL br_stall got=%b exp=0", a_stall); end
    zero = 1'b0;
    #1;
    checks++; if (a_pcsrc !== 1'b0) begin failures++; $display("FAIL br_not_taken got=%b exp=0", a_pcsrc); end
    @(posedge clk); #1;
    memc = 3'b000;
  endtask

  task automatic test_store_load();
    int st, bb;
    memc = 3'b001; res = 32'h10; wd = 32'hDEADBEEF; wbc = 2'b00; wr = 5'd0;
    exec(1'b0, st, bb);
    checks++; if (st !== LAT_A) begin failures++; $display("FAIL sw_stalls got=%0d exp=%0d", st, LAT_A); end
    checks++; if (bb !== 0) begin failures++; $display("FAIL sw_bubble got=%0d exp=0", bb); end
    memc = 3'b010; res = 32'h10; wbc = 2'b11; wr = 5'd9;
    exec(1'b0, st, bb);
    checks++; if (st !== LAT_A) begin failures++; $display("FAIL lw_stalls got=%0d exp=%0d", st, LAT_A); end
    checks++; if (bb !== 0) begin failures++; $display("FAIL lw_bubble got=%0d exp=0", bb); end
    checks++; if (a_rd !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_rd got=%h exp=deadbeef", a_rd); end
    checks++; if (a_wbd !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_wbd got=%h exp=deadbeef", a_wbd); end
    checks++; if (a_wbc !== 2'b11) begin failures++; $display("FAIL lw_wbc got=%b exp=11", a_wbc); end
    memc = 3'b000;
  endtask

  task automatic test_reset_mid();
    int st, bb;
    memc = 3'b001; res = 32'h20; wd = 32'h0; wbc = 2'b00;
    exec(1'b0, st, bb);
    checks++; if (st !== LAT_A) begin failures++; $display("FAIL mid_sw0_stalls got=%0d exp=%0d", st, LAT_A); end
    wd = 32'h55;
    #1;
    checks++; if (a_stall !== 1'b1) begin failures++; $display("FAIL mid_accept got=%b exp=1", a_stall); end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++; if (a_stall !== 1'b0) begin failures++; $display("FAIL mid_rst_stall got=%b exp=0", a_stall); end
    @(posedge clk); #1;
    rst = 1'b0; memc = 3'b000;
    #1;
    checks++; if (a_stall !== 1'b0) begin failures++; $display("FAIL mid_post_stall got=%b exp=0", a_stall); end
    checks++; if (a_wbc !== 2'b00) begin failures++; $display("FAIL mid_post_wbc got=%b exp=0", a_wbc); end
    memc = 3'b010; res = 32'h20; wbc = 2'b11;
    exec(1'b0, st, bb);
    checks++; if (a_rd !== 32'h0) begin failures++; $display("FAIL mid_lw_rd got=%h exp=0", a_rd); end
    memc = 3'b000;
  endtask

  task automatic test_wrap_lat0();
    int st, bb;
    pulse_reset();
    memc = 3'b001; res = 32'h400; wd = 32'hA5; wbc = 2'b00;
    exec(1'b1, st, bb);
    checks++; if (st !== 0) begin failures++; $display("FAIL wrap_sw_stalls got=%0d exp=0", st); end
    memc = 3'b010; res = 32'h000; wbc = 2'b11;
    exec(1'b1, st, bb);
    checks++; if (st !== 0) begin failures++; $display("FAIL wrap_lw_stalls got=%0d exp=0", st); end
    checks++; if (z_rd !== 32'hA5) begin failures++; $display("FAIL wrap_lw_rd got=%h exp=a5", z_rd); end
    checks++; if (z_wbd !== 32'hA5) begin failures++; $display("FAIL wrap_lw_wbd got=%h exp=a5", z_wbd); end
    memc = 3'b000;
  endtask

  // Transaction-level model: memory array plus the architectural MEM/WB values.
  task automatic test_random(input bit use_z, input int n);
    logic [31:0] mm [256];
    logic [31:0] rd_m, res_m, wbd_m;
    logic [4:0]  wr_m;
    logic [1:0]  wbc_m;
    logic [7:0]  wa;
    logic [31:0] o_rd, o_res, o_wbd;
    logic [4:0]  o_wr;
    logic [1:0]  o_wbc;
    int st, bb, exp_st, k;
    bit isw, isr;
    pulse_reset();
    rd_m = 32'd0;
    for (int a = 0; a < 256; a++) begin
      memc = 3'b001; zero = 1'b0; res = $urandom; res[9:2] = a[7:0];
      wd = $urandom; wr = 5'($urandom); wbc = 2'($urandom); bpc = $urandom;
      mm[a] = wd;
      exec(use_z, st, bb);
      exp_st = use_z ? 0 : LAT_A;
      checks++; if (st !== exp_st) begin failures++; $display("FAIL fill_stalls a=%0d got=%0d exp=%0d", a, st, exp_st); end
    end
    res_m = res; wr_m = wr; wbc_m = wbc;
    for (int i = 0; i < n; i++) begin
      k = $urandom_range(0, 9);
      res = $urandom; wd = $urandom; wr = 5'($urandom); wbc = 2'($urandom);
      bpc = $urandom; zero = 1'($urandom_range(0, 1));
      if (k <= 3) memc = 3'b001;
      else if (k <= 6) memc = 3'b010;
      else if (k == 7) memc = 3'b011;
      else if (k == 8) memc = 3'b000;
      else memc = 3'b100;
      isw = memc[0]; isr = memc[1];
      wa = res[9:2];
      #1;
      checks++; if ((use_z ? z_memd : a_memd) !== res) begin failures++; $display("FAIL rnd_memd i=%0d got=%h exp=%h", i, (use_z ? z_memd : a_memd), res); end
      checks++; if ((use_z ? z_pcsrc : a_pcsrc) !== (memc[2] & zero)) begin failures++; $display("FAIL rnd_pcsrc i=%0d got=%b exp=%b", i, (use_z ? z_pcsrc : a_pcsrc), memc[2] & zero); end
      exec(use_z, st, bb);
      exp_st = ((isw || isr) && !use_z) ? LAT_A : 0;
      if (isw) mm[wa] = wd;
      if (isw && isr) rd_m = 32'd0;
      else if (isr) rd_m = mm[wa];
      res_m = res; wr_m = wr; wbc_m = wbc;
      wbd_m = wbc_m[0] ? rd_m : res_m;
      o_rd  = use_z ? z_rd  : a_rd;
      o_res = use_z ? z_res : a_res;
      o_wr  = use_z ? z_wr  : a_wr;
      o_wbc = use_z ? z_wbc : a_wbc;
      o_wbd = use_z ? z_wbd : a_wbd;
      checks++; if (st !== exp_st) begin failures++; $display("FAIL rnd_stalls i=%0d got=%0d exp=%0d", i, st, exp_st); end
      checks++; if (bb !== 0) begin failures++; $display("FAIL rnd_bubble i=%0d got=%0d exp=0", i, bb); end
      checks++; if (o_rd !== rd_m) begin failures++; $display("FAIL rnd_rd i=%0d got=%h exp=%h", i, o_rd, rd_m); end
      checks++; if (o_res !== res_m) begin failures++; $display("FAIL rnd_res i=%0d got=%h exp=%h", i, o_res, res_m); end
      checks++; if (o_wr !== wr_m) begin failures++; $display("FAIL rnd_wr i=%0d got=%h exp=%h", i, o_wr, wr_m); end
      checks++; if (o_wbc !== wbc_m) begin failures++; $display("FAIL rnd_wbc i=%0d got=%b exp=%b", i, o_wbc, wbc_m); end
      checks++; if (o_wbd !== wbd_m) begin failures++; $display("FAIL rnd_wbd i=%0d got=%h exp=%h", i, o_wbd, wbd_m); end
    end
    memc = 3'b000;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_branch();
    test_store_load();
    test_reset_mid();
    test_random(1'b0, 150);
    test_wrap_lat0();
    test_random(1'b1, 150);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
